// File: rtl/dlatch_pkg.sv
// Shared types and constants for the dlatch write controller.
package dlatch_pkg;

   localparam int unsigned BEAT_W = 16;
   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] INIT_VALUE = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

endpackage

// File: rtl/dlatch_ctrl_if.sv
// Two-requester write bus. A word transfers on an edge where Valid_i[n] & Ready_o[n];
// Ready_o is at most one-hot and Data<n>_i must be stable while Valid_i[n] is high.
interface dlatch_ctrl_if;
   import dlatch_pkg::*;

   logic [1:0]        Valid_i;
   logic [WORD_W-1:0] Data0_i;
   logic [WORD_W-1:0] Data1_i;
   logic [1:0]        Ready_o;

   modport master (output Valid_i, output Data0_i, output Data1_i, input Ready_o);
   modport slave  (input Valid_i, input Data0_i, input Data1_i, output Ready_o);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advances on accept.
module rr_arb2 (
   input  logic       Clk_i,
   input  logic       Reset_n_i,
   input  logic [1:0] Req_i,
   input  logic       Accept_i,
   output logic [1:0] Grant_o,
   output logic       Ptr_o
);

   logic ptr;

   always_comb begin
      Grant_o = 2'b00;
      case (Req_i)
         2'b01:   Grant_o = 2'b01;
         2'b10:   Grant_o = 2'b10;
         2'b11:   Grant_o = ptr ? 2'b10 : 2'b01;
         default: Grant_o = 2'b00;
      endcase
   end

   // After a grant the pointer favours whichever requester was not served.
   always_ff @(posedge Clk_i) begin
      if (!Reset_n_i) begin
         ptr <= 1'b0;
      end else if (Accept_i) begin
         ptr <= Grant_o[0];
      end
   end

   assign Ptr_o = ptr;

endmodule

// File: rtl/dlatch_ctrl.sv
// Arbitrates two word writers and serialises each accepted word into two 16-bit
// beats (high half first) for a dlatch, mirroring the last complete word in Shadow_o.
module dlatch_ctrl
   import dlatch_pkg::*;
#(
   parameter logic [WORD_W-1:0] Init = INIT_VALUE,
   parameter int unsigned       Gap  = 0
) (
   input  logic              Clk_i,
   input  logic              Reset_n_i,
   dlatch_ctrl_if.slave      req,
   output logic              Wen_o,
   output logic [BEAT_W-1:0] Data_o,
   output logic              Busy_o,
   output logic [WORD_W-1:0] Shadow_o,
   output state_e            State_o,
   output logic              Ptr_o
);

   localparam logic [3:0] GAP_LOAD = 4'((Gap == 0) ? 0 : Gap - 1);

   state_e            state;
   logic [WORD_W-1:0] word;
   logic [WORD_W-1:0] shadow;
   logic [3:0]        gap_cnt;
   logic              wen;
   logic [BEAT_W-1:0] data;
   logic [1:0]        grant;
   logic [1:0]        ready;
   logic              transfer;
   logic [WORD_W-1:0] sel_word;

   rr_arb2 u_arb (
      .Clk_i     (Clk_i),
      .Reset_n_i (Reset_n_i),
      .Req_i     (req.Valid_i),
      .Accept_i  (transfer),
      .Grant_o   (grant),
      .Ptr_o     (Ptr_o)
   );

   // Only offer a grant while idle and out of reset.
   assign ready       = (state == ST_IDLE && Reset_n_i) ? grant : 2'b00;
   assign req.Ready_o = ready;
   assign transfer    = |(req.Valid_i & ready);
   assign sel_word    = ready[1] ? req.Data1_i : req.Data0_i;

   // Wen/Data are registered alongside the state so they line up with HI and LO.
   always_ff @(posedge Clk_i) begin
      if (!Reset_n_i) begin
         state   <= ST_IDLE;
         word    <= '0;
         shadow  <= Init;
         gap_cnt <= '0;
         wen     <= 1'b0;
         data    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (transfer) begin
                  word  <= sel_word;
                  wen   <= 1'b1;
                  data  <= sel_word[WORD_W-1:BEAT_W];
                  state <= ST_HI;
               end
            end
            ST_HI: begin
               data  <= word[BEAT_W-1:0];
               state <= ST_LO;
            end
            ST_LO: begin
               shadow <= word;
               wen    <= 1'b0;
               data   <= '0;
               if (Gap > 0) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_cnt == 4'd0) state <= ST_IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign Wen_o    = wen;
   assign Data_o   = data;
   assign Busy_o   = (state != ST_IDLE);
   assign Shadow_o = shadow;
   assign State_o  = state;

endmodule

// File: tb/tb_dlatch_ctrl.sv
// Directed bench: one controller with Gap=0 and one with Gap=2 share clock and reset.
module tb_dlatch_ctrl;
   import dlatch_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dlatch_ctrl_if bus_a ();
   dlatch_ctrl_if bus_b ();

   logic        wen_a, wen_b, busy_a, busy_b, ptr_a, ptr_b;
   logic [15:0] data_a, data_b;
   logic [31:0] shadow_a, shadow_b;
   state_e      state_a, state_b;

   dlatch_ctrl #(.Init(32'hDEADBEEF), .Gap(0)) u_dut_a (
      .Clk_i(clk), .Reset_n_i(rst_n), .req(bus_a.slave),
      .Wen_o(wen_a), .Data_o(data_a), .Busy_o(busy_a), .Shadow_o(shadow_a),
      .State_o(state_a), .Ptr_o(ptr_a)
   );

   dlatch_ctrl #(.Init(32'hDEADBEEF), .Gap(2)) u_dut_b (
      .Clk_i(clk), .Reset_n_i(rst_n), .req(bus_b.slave),
      .Wen_o(wen_b), .Data_o(data_b), .Busy_o(busy_b), .Shadow_o(shadow_b),
      .State_o(state_b), .Ptr_o(ptr_b)
   );

   int vectors = 0;
   int miscompares = 0;
   int run_a = 0;
   int run_b = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants sampled mid-cycle for both instances.
   always @(negedge clk) begin
      run_a = wen_a ? run_a + 1 : 0;
      run_b = wen_b ? run_b + 1 : 0;
      chk("mon_wen_run_a", 32'(run_a <= 2), 32'd1);
      chk("mon_wen_run_b", 32'(run_b <= 2), 32'd1);
      chk("mon_ready_not11_a", 32'(bus_a.Ready_o != 2'b11), 32'd1);
      chk("mon_ready_not11_b", 32'(bus_b.Ready_o != 2'b11), 32'd1);
      if (busy_a) chk("mon_ready_busy_a", 32'(bus_a.Ready_o), 32'd0);
      if (busy_b) chk("mon_ready_busy_b", 32'(bus_b.Ready_o), 32'd0);
      if (!rst_n) chk("mon_ready_rst_a", 32'(bus_a.Ready_o), 32'd0);
   end

   logic [31:0] words [4];
   logic [1:0]  grants [4];

   initial begin
      bus_a.Valid_i = 2'b00; bus_a.Data0_i = '0; bus_a.Data1_i = '0;
      bus_b.Valid_i = 2'b00; bus_b.Data0_i = '0; bus_b.Data1_i = '0;

      // Reset state, including a request held during reset.
      tick(); tick();
      bus_a.Valid_i = 2'b01; bus_a.Data0_i = 32'h12345678;
      #1;
      chk("rst_ready", 32'(bus_a.Ready_o), 32'd0);
      chk("rst_shadow", shadow_a, 32'hDEADBEEF);
      chk("rst_wen", 32'(wen_a), 32'd0);
      chk("rst_data", 32'(data_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_state", 32'(state_a), 32'(ST_IDLE));
      chk("rst_ptr", 32'(ptr_a), 32'd0);

      // Single word from requester 0.
      rst_n = 1'b1;
      #1;
      chk("w1_ready", 32'(bus_a.Ready_o), 32'd1);
      tick();
      bus_a.Valid_i = 2'b00;
      chk("w1_hi_wen", 32'(wen_a), 32'd1);
      chk("w1_hi_data", 32'(data_a), 32'h1234);
      chk("w1_hi_ready", 32'(bus_a.Ready_o), 32'd0);
      chk("w1_hi_busy", 32'(busy_a), 32'd1);
      tick();
      chk("w1_lo_wen", 32'(wen_a), 32'd1);
      chk("w1_lo_data", 32'(data_a), 32'h5678);
      chk("w1_lo_shadow", shadow_a, 32'hDEADBEEF);
      tick();
      chk("w1_end_shadow", shadow_a, 32'h12345678);
      chk("w1_end_wen", 32'(wen_a), 32'd0);
      chk("w1_end_data", 32'(data_a), 32'd0);
      chk("w1_end_busy", 32'(busy_a), 32'd0);
      chk("w1_end_ptr", 32'(ptr_a), 32'd1);

      // Both requesters held: grants alternate 0,1,0,1 at one word per 3 cycles.
      rst_n = 1'b0;
      tick();
      chk("rr_rst_ptr", 32'(ptr_a), 32'd0);
      rst_n = 1'b1;
      bus_a.Valid_i = 2'b11; bus_a.Data0_i = 32'hAAAA5555; bus_a.Data1_i = 32'hBBBB6666;
      words[0] = 32'hAAAA5555; words[1] = 32'hBBBB6666;
      words[2] = 32'hAAAA5555; words[3] = 32'hBBBB6666;
      grants[0] = 2'b01; grants[1] = 2'b10; grants[2] = 2'b01; grants[3] = 2'b10;
      #1;
      for (int w = 0; w < 4; w++) begin
         chk("rr_ready", 32'(bus_a.Ready_o), 32'(grants[w]));
         chk("rr_idle_busy", 32'(busy_a), 32'd0);
         tick();
         chk("rr_hi_data", 32'(data_a), 32'(words[w][31:16]));
         chk("rr_hi_busy", 32'(busy_a), 32'd1);
         tick();
         chk("rr_lo_data", 32'(data_a), 32'(words[w][15:0]));
         tick();
         chk("rr_shadow", shadow_a, words[w]);
         chk("rr_end_wen", 32'(wen_a), 32'd0);
      end
      bus_a.Valid_i = 2'b00;
      #1;
      chk("rr_drop_ready", 32'(bus_a.Ready_o), 32'd0);
      tick();
      chk("rr_drop_state", 32'(state_a), 32'(ST_IDLE));
      chk("rr_drop_busy", 32'(busy_a), 32'd0);

      // Gap=2 instance: Wen 1,1,0,0 then Ready returns.
      bus_b.Valid_i = 2'b10; bus_b.Data1_i = 32'hCAFEF00D;
      #1;
      chk("gap_ready0", 32'(bus_b.Ready_o), 32'd2);
      tick();
      chk("gap_c1_wen", 32'(wen_b), 32'd1);
      chk("gap_c1_data", 32'(data_b), 32'hCAFE);
      tick();
      chk("gap_c2_wen", 32'(wen_b), 32'd1);
      chk("gap_c2_data", 32'(data_b), 32'hF00D);
      tick();
      chk("gap_c3_wen", 32'(wen_b), 32'd0);
      chk("gap_c3_data", 32'(data_b), 32'd0);
      chk("gap_c3_busy", 32'(busy_b), 32'd1);
      chk("gap_c3_ready", 32'(bus_b.Ready_o), 32'd0);
      chk("gap_c3_shadow", shadow_b, 32'hCAFEF00D);
      tick();
      chk("gap_c4_wen", 32'(wen_b), 32'd0);
      chk("gap_c4_ready", 32'(bus_b.Ready_o), 32'd0);
      tick();
      chk("gap_c5_ready", 32'(bus_b.Ready_o), 32'd2);
      chk("gap_c5_busy", 32'(busy_b), 32'd0);
      bus_b.Valid_i = 2'b00;

      // Reset during LO aborts the word and restores Init.
      bus_a.Valid_i = 2'b01; bus_a.Data0_i = 32'h0BADF00D;
      #1;
      chk("abort_ready", 32'(bus_a.Ready_o), 32'd1);
      tick();
      bus_a.Valid_i = 2'b00;
      chk("abort_ptr_moved", 32'(ptr_a), 32'd1);
      tick();
      chk("abort_lo_wen", 32'(wen_a), 32'd1);
      chk("abort_lo_state", 32'(state_a), 32'(ST_LO));
      rst_n = 1'b0;
      tick();
      chk("abort_wen", 32'(wen_a), 32'd0);
      chk("abort_shadow", shadow_a, 32'hDEADBEEF);
      chk("abort_state", 32'(state_a), 32'(ST_IDLE));
      chk("abort_ptr", 32'(ptr_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("abort_after_wen", 32'(wen_a), 32'd0);
      chk("abort_after_shadow", shadow_a, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
